hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised pipeline hazard controller for the Riscy SoC core. It replaces single-entry load-use detection with a DEPTH-entry in-order scoreboard of outstanding load destinations. It adds fence draining, branch-mispredict squash of speculative loads, and per-bus wait timeouts. It produces stall and flush for the fetch, decode, execute and mem stages, with the same stage chaining as the existing hazard logic.

## Interface
Parameters:
- REG_W, 9, register-specifier width
- DEPTH, 4, scoreboard entries (power of two, ≥2)
- TIMEOUT, 256, bus wait cycles before a timeout pulse (≥2)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- issue_valid_in  in  1  decode holds a valid instruction wanting to enter execute
- issue_rs1_in / issue_rs2_in  in  REG_W  source registers
- issue_rs1_read_in / issue_rs2_read_in  in  1  source is used
- issue_rd_in  in  REG_W  destination register
- issue_rd_write_in  in  1  destination is written
- issue_mem_read_in  in  1  instruction is a load
- issue_fence_in  in  1  instruction is a fence
- mem_accept_in  in  1  oldest speculative load entered mem this cycle
- retire_valid_in  in  1  oldest load wrote back this cycle
- mem_branch_mispredicted_in  in  1  mispredict resolved in mem
- instr_read_in, instr_ready_in, data_read_in, data_write_in, data_ready_in  in  1  bus handshakes
- fetch/decode/execute/mem _stall_out, _flush_out  out  1 each  stage controls (combinational)
- sb_count_out  out  $clog2(DEPTH)+1  valid entries (registered)
- bus_timeout_out  out  2  [0] instr, [1] data; one-cycle pulses (registered)
- sb_error_out  out  1  sticky: retire or accept with no eligible entry

## Operation
- Scoreboard: circular FIFO of {rd, spec}, head/tail pointers, count 0..DEPTH.
- mem_wait = (data_read_in|data_write_in) & !data_ready_in. fetch_wait = instr_read_in & !instr_ready_in.
- Chain: mem_stall = mem_wait; execute_stall = mem_stall; decode_stall = execute_stall; fetch_stall = decode_stall | issue_block | fetch_wait.
- Flushes: fetch_flush = 0; decode_flush = fetch_stall | mispredict; execute_flush = decode_stall | mispredict; mem_flush = execute_stall.
- Entries are eligible for a hazard match if valid and not the head entry being retired this cycle. This is writeback bypass.
- raw = issue_valid & rd of any eligible entry equals (rs1 & rs1_read) or (rs2 & rs2_read). Entries with rd=0 never exist.
- full_block = issue_mem_read & count==DEPTH & !retire_valid_in.
- fence_block = issue_fence & (count!=0 | mem_wait).
- issue_block = raw | full_block | fence_block.
- fire = issue_valid & !fetch_stall & !mispredict.
- alloc = fire & issue_mem_read & issue_rd_write & rd!=0. On alloc, push {rd, spec=1} at tail.
- mem_accept_in clears spec on the oldest spec=1 entry.
- retire_valid_in pops the head; the popped entry must have spec=0.
- Mispredict discards all spec=1 entries (always the youngest). It is applied after that cycle's accept, and alloc is suppressed. count -= remaining spec entries.
- Timeout: one counter per bus. It increments while its wait is true and clears when the wait is false. On reaching TIMEOUT-1 it pulses its bus_timeout_out bit and wraps to 0. Stalls are not altered.
- sb_error_out is set by: retire while count==0 or head spec=1; or accept with no spec=1 entry. The offending event is ignored.

## Timing
- Reset values: count=0, pointers=0, spec bits=0, counters=0, bus_timeout_out=0, sb_error_out=0. Stall/flush outputs then follow only the bus inputs.
- All scoreboard updates occur at the clk edge after the event. sb_count_out reflects them the next cycle.
- Same cycle retire and alloc: count unchanged, allowed at full.
- Same cycle retire and raw on the head rd: no stall.
- A load-use stall lasts until the matching retire cycle (inclusive bypass).
- Reset mid-operation clears all state immediately and asynchronously.

## Test plan
- Load x5 issues (count 0→1), then "add x6,x5,x1" issues: fetch_stall=1 and decode_flush=1 until the retire cycle. The add fires in the retire cycle, and count returns to 0.
- Four loads to x1..x4 with no retire: count=4. A fifth load stalls. Asserting retire in the same cycle lets it fire, and count stays 4.
- Two loads, one mem_accept, then mispredict: count 2→1. Retiring the remaining entry gives count 0 and sb_error_out=0.
- Fence with count=2: stalled through two retires, fires the cycle count==0 and mem_wait=0.
- data_read_in=1, data_ready_in=0 held 256 cycles with TIMEOUT=256: bus_timeout_out[1] pulses on cycle 256, again at 512. mem/execute/decode stalls stay 1 throughout.
- Retire with count=0: sb_error_out=1 sticky, count stays 0. Assert reset mid-load-stall: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: in-order scoreboard of outstanding load destinations,
// fence draining, mispredict squash of speculative loads, and per-bus wait timeouts.
module hazard_scoreboard #(
    parameter int unsigned REG_W   = 9,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid_in,
    input  logic [REG_W-1:0]           issue_rs1_in,
    input  logic [REG_W-1:0]           issue_rs2_in,
    input  logic                       issue_rs1_read_in,
    input  logic                       issue_rs2_read_in,
    input  logic [REG_W-1:0]           issue_rd_in,
    input  logic                       issue_rd_write_in,
    input  logic                       issue_mem_read_in,
    input  logic                       issue_fence_in,
    input  logic                       mem_accept_in,
    input  logic                       retire_valid_in,
    input  logic                       mem_branch_mispredicted_in,
    input  logic                       instr_read_in,
    input  logic                       instr_ready_in,
    input  logic                       data_read_in,
    input  logic                       data_write_in,
    input  logic                       data_ready_in,
    output logic                       fetch_stall_out,
    output logic                       fetch_flush_out,
    output logic                       decode_stall_out,
    output logic                       decode_flush_out,
    output logic                       execute_stall_out,
    output logic                       execute_flush_out,
    output logic                       mem_stall_out,
    output logic                       mem_flush_out,
    output logic [$clog2(DEPTH):0]     sb_count_out,
    output logic [1:0]                 bus_timeout_out,
    output logic                       sb_error_out
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    logic [REG_W-1:0] rd_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    spec_cnt_q;
    logic [TW-1:0]    itmo_q;
    logic [TW-1:0]    dtmo_q;
    logic [1:0]       bus_timeout_q;
    logic             err_q;

    logic             mem_wait;
    logic             fetch_wait;
    logic             retire_ok;
    logic             accept_ok;
    logic             raw;
    logic             full_block;
    logic             fence_block;
    logic             issue_block;
    logic             fire;
    logic             alloc;
    logic [CW-1:0]    spec_left;

    assign mem_wait   = (data_read_in | data_write_in) & ~data_ready_in;
    assign fetch_wait = instr_read_in & ~instr_ready_in;

    // Speculative entries are always the youngest spec_cnt_q entries, so the head
    // is speculative exactly when every valid entry is.
    assign retire_ok  = retire_valid_in & (count_q != '0) & (spec_cnt_q != count_q);
    assign accept_ok  = mem_accept_in & (spec_cnt_q != '0);
    assign spec_left  = spec_cnt_q - CW'(accept_ok);

    // Source match against live entries; the head retiring this cycle is bypassed.
    always_comb begin
        raw = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(PW'(i) - head_q)} < count_q) &&
                !(retire_ok && (PW'(i) == head_q)) &&
                ((issue_rs1_read_in && (rd_q[PW'(i)] == issue_rs1_in)) ||
                 (issue_rs2_read_in && (rd_q[PW'(i)] == issue_rs2_in)))) begin
                raw = 1'b1;
            end
        end
        raw = raw & issue_valid_in;
    end

    assign full_block  = issue_valid_in & issue_mem_read_in & (count_q == CW'(DEPTH)) & ~retire_ok;
    assign fence_block = issue_valid_in & issue_fence_in & ((count_q != '0) | mem_wait);
    assign issue_block = raw | full_block | fence_block;

    assign mem_stall_out     = mem_wait;
    assign execute_stall_out = mem_stall_out;
    assign decode_stall_out  = execute_stall_out;
    assign fetch_stall_out   = decode_stall_out | issue_block | fetch_wait;
    assign fetch_flush_out   = 1'b0;
    assign decode_flush_out  = fetch_stall_out | mem_branch_mispredicted_in;
    assign execute_flush_out = decode_stall_out | mem_branch_mispredicted_in;
    assign mem_flush_out     = execute_stall_out;

    assign fire  = issue_valid_in & ~fetch_stall_out & ~mem_branch_mispredicted_in;
    assign alloc = fire & issue_mem_read_in & issue_rd_write_in & (issue_rd_in != '0);

    // Scoreboard state; mispredict drops the speculative tail left after this cycle's accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) rd_q[PW'(i)] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            spec_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (alloc) rd_q[tail_q] <= issue_rd_in;
            head_q <= head_q + PW'(retire_ok);
            if (mem_branch_mispredicted_in) begin
                tail_q     <= tail_q - PW'(spec_left);
                count_q    <= count_q - CW'(retire_ok) - spec_left;
                spec_cnt_q <= '0;
            end else begin
                tail_q     <= tail_q + PW'(alloc);
                count_q    <= count_q + CW'(alloc) - CW'(retire_ok);
                spec_cnt_q <= spec_left + CW'(alloc);
            end
            if ((retire_valid_in && !retire_ok) || (mem_accept_in && !accept_ok)) err_q <= 1'b1;
        end
    end

    // Per-bus wait counters; pulse and wrap every TIMEOUT consecutive wait cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            itmo_q        <= '0;
            dtmo_q        <= '0;
            bus_timeout_q <= '0;
        end else begin
            bus_timeout_q[0] <= fetch_wait && (itmo_q == TW'(TIMEOUT - 1));
            bus_timeout_q[1] <= mem_wait && (dtmo_q == TW'(TIMEOUT - 1));
            if (!fetch_wait || (itmo_q == TW'(TIMEOUT - 1))) itmo_q <= '0;
            else                                              itmo_q <= itmo_q + TW'(1);
            if (!mem_wait || (dtmo_q == TW'(TIMEOUT - 1)))    dtmo_q <= '0;
            else                                              dtmo_q <= dtmo_q + TW'(1);
        end
    end

    assign sb_count_out    = count_q;
    assign bus_timeout_out = bus_timeout_q;
    assign sb_error_out    = err_q;

endmodule
